// File: rtl/gf2m_fifo_multiplier_if.sv
// Handshake bundle between the operand FIFOs, the GF(2^m) multiplier and the
// point-arithmetic consumer. "slave" is the multiplier's view.
interface gf2m_fifo_multiplier_if #(
    parameter int DATA = 256
);
    logic            A_Out_Busy;
    logic            B_Out_Busy;
    logic [DATA-1:0] A_Data;
    logic [DATA-1:0] B_Data;
    logic            A_rd_en;
    logic            B_rd_en;
    logic [DATA-1:0] result;
    logic            result_valid;
    logic            result_ready;
    logic            busy;

    modport slave (
        input  A_Out_Busy, B_Out_Busy, A_Data, B_Data, result_ready,
        output A_rd_en, B_rd_en, result, result_valid, busy
    );

    modport master (
        output A_Out_Busy, B_Out_Busy, A_Data, B_Data, result_ready,
        input  A_rd_en, B_rd_en, result, result_valid, busy
    );
endinterface

// File: rtl/gf2m_fifo_multiplier.sv
// Pops one operand pair from FIFO A/B, computes A*B mod f(x) bit-serially (MSB first)
// and holds the zero-extended product on a valid/ready handshake.
module gf2m_fifo_multiplier #(
    parameter int             DATA = 256,
    parameter int             M    = 233,
    parameter logic [M-1:0]   POLY = ({{(M-1){1'b0}}, 1'b1} << 7'd74) | {{(M-1){1'b0}}, 1'b1}
) (
    input  logic                   clk,
    input  logic                   rst,
    gf2m_fifo_multiplier_if.slave  bus
);

    localparam int CW = $clog2(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [M-1:0]    r_a;
    logic [M-1:0]    r_b;
    logic [M-1:0]    r_c;
    logic [CW-1:0]   r_cnt;
    logic [DATA-1:0] r_result;
    logic            r_result_valid;
    logic            r_rd_en;
    logic            r_busy;
    logic [M-1:0]    w_c_next;

    // One Horner step: c*x reduced by f(x), plus a when the current b bit is set.
    function automatic logic [M-1:0] gf_mac_step(
        input logic [M-1:0] c,
        input logic [M-1:0] a,
        input logic         b_bit
    );
        logic [M-1:0] t;
        t = {c[M-2:0], 1'b0};
        if (c[M-1]) begin
            t = t ^ POLY;
        end else begin
            t = t;
        end
        if (b_bit) begin
            t = t ^ a;
        end else begin
            t = t;
        end
        return t;
    endfunction

    // Next accumulator value for the current MUL iteration.
    always_comb begin
        w_c_next = gf_mac_step(r_c, r_a, r_b[r_cnt]);
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_a            <= {M{1'b0}};
            r_b            <= {M{1'b0}};
            r_c            <= {M{1'b0}};
            r_cnt          <= CNT_ZERO;
            r_result       <= {DATA{1'b0}};
            r_result_valid <= 1'b0;
            r_rd_en        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.A_Out_Busy && !bus.B_Out_Busy) begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                    r_rd_en <= 1'b0;
                end
                S_LOAD: begin
                    // FIFO outputs are registered, so the popped pair is visible now.
                    r_a     <= bus.A_Data[M-1:0];
                    r_b     <= bus.B_Data[M-1:0];
                    r_c     <= {M{1'b0}};
                    r_cnt   <= CNT_LAST;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_c <= w_c_next;
                    if (r_cnt == CNT_ZERO) begin
                        r_result       <= {{(DATA-M){1'b0}}, w_c_next};
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_rd_en        <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A_rd_en      = r_rd_en;
    assign bus.B_rd_en      = r_rd_en;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_gf2m_fifo_multiplier.sv
// Self-checking bench: queue-based FIFO models, polynomial reference model,
// directed corner cases and a randomized phase with random backpressure.
module tb_gf2m_fifo_multiplier;

    localparam int DATA = 256;
    localparam int M    = 233;
    localparam int NRND = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf2m_fifo_multiplier_if #(.DATA(DATA)) bus();
    gf2m_fifo_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [DATA-1:0] qa[$];
    logic [DATA-1:0] qb[$];
    logic [DATA-1:0] exp_q[$];
    int   rd_pulses     = 0;
    int   n_results     = 0;
    int   last_rd_cyc   = 0;
    int   last_valid_cyc = 0;
    logic prev_rd    = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Reference: full carry-less product, then long division by f(x) = x^M + x^74 + 1.
    function automatic logic [DATA-1:0] gf_ref(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
        logic [511:0] p;
        logic [511:0] f;
        logic [511:0] am;
        p  = 512'd0;
        am = 512'(a[M-1:0]);
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ (am << i);
        end
        f = (512'd1 << M) | (512'd1 << 74) | 512'd1;
        for (int i = 2*M-2; i >= M; i--) begin
            if (p[i]) p = p ^ (f << (i - M));
        end
        return DATA'(p[M-1:0]);
    endfunction

    function automatic logic [DATA-1:0] rnd256();
        logic [DATA-1:0] r;
        for (int i = 0; i < DATA/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: registered Data_out one cycle after rd_en, empty flag tracks occupancy.
    always @(posedge clk) begin
        if (bus.A_rd_en && qa.size() > 0) bus.A_Data <= qa.pop_front();
        if (bus.B_rd_en && qb.size() > 0) bus.B_Data <= qb.pop_front();
        bus.A_Out_Busy <= (qa.size() == 0);
        bus.B_Out_Busy <= (qb.size() == 0);
    end

    // Monitor: strobe discipline and in-order result scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.A_rd_en || bus.B_rd_en) begin
                check_eq("rd_en_pair", bus.A_rd_en, bus.B_rd_en);
                check_eq("rd_en_one_cycle", prev_rd, 1'b0);
                check_eq("pop_a_nonempty", qa.size() > 0, 1'b1);
                check_eq("pop_b_nonempty", qb.size() > 0, 1'b1);
                rd_pulses   <= rd_pulses + 1;
                last_rd_cyc <= cyc;
            end
            if (bus.result_valid && !prev_valid) last_valid_cyc <= cyc;
            if (bus.result_valid && bus.result_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_result", bus.result_valid, 1'b0);
                else                   check_eq("result", bus.result, exp_q.pop_front());
                n_results <= n_results + 1;
            end
            prev_rd    <= bus.A_rd_en | bus.B_rd_en;
            prev_valid <= bus.result_valid;
        end else begin
            prev_rd    <= 1'b0;
            prev_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
        qa.push_back(a);
        qb.push_back(b);
        exp_q.push_back(gf_ref(a, b));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, (exp_q.size() == 0) && !bus.busy, 1'b1);
    endtask

    initial begin
        int p0;
        int r0;
        int n;
        int ia;
        int ib;
        logic            stable;
        logic [DATA-1:0] held;
        logic [DATA-1:0] ra[NRND];
        logic [DATA-1:0] rb[NRND];

        bus.result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", bus.result, '0);
        check_eq("rst_valid", bus.result_valid, 1'b0);
        check_eq("rst_rd_a", bus.A_rd_en, 1'b0);
        check_eq("rst_rd_b", bus.B_rd_en, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();

        // 1*1, one pulse, rd_en-to-valid distance
        p0 = rd_pulses;
        push_pair(256'd1, 256'd1);
        wait_drain("t1_drain", 400);
        check_eq("t1_one_pulse", rd_pulses - p0, 1);
        check_eq("t1_latency", last_valid_cyc - last_rd_cyc, 235);
        check_eq("t1_value", bus.result, 256'd1);

        // x * x^232 wraps to x^74 + 1
        push_pair(256'd2, 256'd1 << 232);
        wait_drain("t2_drain", 400);
        check_eq("t2_x233", bus.result, (256'd1 << 74) | 256'd1);

        // zero operand, then ignored upper bits
        push_pair(256'd0, {DATA{1'b1}});
        push_pair((256'd1 << 255) | 256'd3, 256'd1);
        wait_drain("t3_drain", 800);
        check_eq("t3_upper_ignored", bus.result, 256'd3);

        // FIFO B empty: nothing popped
        p0 = rd_pulses;
        ra[0] = rnd256(); ra[1] = rnd256(); rb[0] = rnd256(); rb[1] = rnd256();
        qa.push_back(ra[0]);
        qa.push_back(ra[1]);
        repeat (50) tick();
        check_eq("starve_no_rd", rd_pulses - p0, 0);
        check_eq("starve_idle", bus.busy, 1'b0);
        qb.push_back(rb[0]);
        qb.push_back(rb[1]);
        exp_q.push_back(gf_ref(ra[0], rb[0]));
        exp_q.push_back(gf_ref(ra[1], rb[1]));
        wait_drain("starve_drain", 800);
        check_eq("starve_two_pops", rd_pulses - p0, 2);

        // backpressure hold, then refetch two cycles after the handshake cycle
        bus.result_ready = 1'b0;
        push_pair(rnd256(), rnd256());
        push_pair(rnd256(), rnd256());
        n = 0;
        while (!bus.result_valid && n < 400) begin tick(); n++; end
        check_eq("bp_valid", bus.result_valid, 1'b1);
        held   = bus.result;
        stable = 1'b1;
        check_eq("bp_value", held, exp_q[0]);
        repeat (20) begin
            tick();
            if (bus.result !== held || !bus.result_valid || bus.A_rd_en || bus.B_rd_en) stable = 1'b0;
        end
        check_eq("bp_stable", stable, 1'b1);
        bus.result_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_hs_valid", bus.result_valid, 1'b1);
        @(negedge clk);
        check_eq("bp_gap_valid", bus.result_valid, 1'b0);
        check_eq("bp_gap_rd", bus.A_rd_en, 1'b0);
        @(negedge clk);
        check_eq("bp_refetch", bus.A_rd_en, 1'b1);
        wait_drain("bp_drain", 800);

        // reset at MUL iteration 100 drops the in-flight pair
        push_pair(rnd256(), rnd256());
        push_pair(rnd256(), rnd256());
        n = 0;
        while (!bus.A_rd_en && n < 100) begin tick(); n++; end
        check_eq("rst_fetch_seen", bus.A_rd_en, 1'b1);
        repeat (101) tick();
        check_eq("rst_mul_busy", bus.busy, 1'b1);
        check_eq("rst_mul_novalid", bus.result_valid, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_async_result", bus.result, '0);
        check_eq("rst_async_valid", bus.result_valid, 1'b0);
        check_eq("rst_async_rd", bus.A_rd_en | bus.B_rd_en, 1'b0);
        check_eq("rst_async_busy", bus.busy, 1'b0);
        void'(exp_q.pop_front());
        r0 = n_results;
        tick();
        rst = 1'b0;
        wait_drain("rst_recover", 800);
        check_eq("rst_one_result", n_results - r0, 1);

        // randomized traffic with independent FIFO fill and random ready
        for (int i = 0; i < NRND; i++) begin
            ra[i] = rnd256();
            rb[i] = rnd256();
            exp_q.push_back(gf_ref(ra[i], rb[i]));
        end
        r0 = n_results;
        ia = 0;
        ib = 0;
        n  = 0;
        while ((ia < NRND || ib < NRND || exp_q.size() != 0) && n < 30000) begin
            tick();
            n++;
            bus.result_ready = ($urandom_range(0, 3) != 0);
            if (ia < NRND && $urandom_range(0, 2) == 0) begin qa.push_back(ra[ia]); ia++; end
            if (ib < NRND && $urandom_range(0, 2) == 0) begin qb.push_back(rb[ib]); ib++; end
        end
        bus.result_ready = 1'b1;
        wait_drain("rand_drain", 2000);
        check_eq("rand_count", n_results - r0, NRND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gf2m_fifo_multiplier.md
# gf2m_fifo_multiplier

Downstream consumer of the two 8-deep 256-bit operand FIFOs (FIFO A, FIFO B) in the sequential ECC datapath. The block pops one operand pair when both FIFOs hold data and computes the binary-field product A·B mod f(x) with a bit-serial, MSB-first shift-and-add multiplier. It then presents the 256-bit zero-extended result on a valid/ready handshake to the point-arithmetic state machine.

## Interface
- DATA, 256, FIFO word width and result width.
- M, 233, field degree; operands use bits [M-1:0], bits [DATA-1:M] are ignored.
- POLY, (1<<74)|1, low M bits of f(x) = x^M + POLY (default x^233 + x^74 + 1).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- A_Out_Busy  in  1  FIFO A empty flag (1 = empty).
- B_Out_Busy  in  1  FIFO B empty flag.
- A_Data  in  DATA  FIFO A Data_out (registered; valid the cycle after rd_en).
- B_Data  in  DATA  FIFO B Data_out.
- A_rd_en  out  1  read strobe to FIFO A.
- B_rd_en  out  1  read strobe to FIFO B.
- result  out  DATA  product, bits [DATA-1:M] always 0.
- result_valid  out  1  result held and valid.
- result_ready  in  1  consumer accepts result.
- busy  out  1  1 in any state other than IDLE.

## Operation
- Reset values: state IDLE, A_rd_en=B_rd_en=0, result=0, result_valid=0, busy=0, a_reg=b_reg=c_reg=0, bit counter=0.
- FSM states IDLE, FETCH, LOAD, MUL, DONE:
  - IDLE: if A_Out_Busy=0 and B_Out_Busy=0, go to FETCH; otherwise stay.
  - FETCH: A_rd_en=B_rd_en=1 for exactly this one cycle, then go to LOAD. The strobes are Moore outputs and are never asserted in any other state.
  - LOAD: capture a_reg=A_Data[M-1:0], b_reg=B_Data[M-1:0], c_reg=0, counter=M-1, then go to MUL.
  - MUL: once per cycle, compute t = c_reg shifted left 1 (within M+1 bits). If t[M]=1, set c_reg = t[M-1:0] ^ POLY; otherwise c_reg = t[M-1:0]. If b_reg[counter]=1, also XOR in a_reg. When counter=0, write c_reg to the result register and go to DONE; otherwise decrement counter.
  - DONE: result_valid=1. When result_ready=1, the transfer completes that cycle and the state goes to IDLE. While result_ready=0, result and result_valid hold.
- Only one operation is ever in flight. No pop occurs while a result is pending, so FIFO data is never lost.
- A single empty FIFO blocks the block indefinitely. It never reads one side alone.
- The empty flags are sampled only in IDLE. Changes on them in other states have no effect.
- result is 0 below the valid state only after reset. Between operations, result keeps the last value until the next MUL completes.
- Reset asserted in any state returns every register to its reset value on the same edge. A FIFO read strobe interrupted by reset is not retried; the popped pair is discarded.

## Timing
- Cycle 0: IDLE with both FIFOs non-empty.
- Cycle 1: FETCH, rd_en high.
- Cycle 2: LOAD, FIFO Data_out valid and captured.
- Cycles 3 .. M+2: MUL, M iterations.
- Cycle M+3: DONE, result_valid=1. Default latency is 236 cycles from the IDLE decision to result_valid.
- Back-to-back throughput: M+4 cycles per product when result_ready is tied high, because DONE→IDLE costs one cycle.
- result_valid drops the cycle after the handshake (result_valid & result_ready).

## Test plan
- Load A=1, B=1 into the FIFOs → exactly one A_rd_en/B_rd_en pulse at cycle 1, result=1 with result_valid at cycle 236.
- A=2 (x), B=1<<232 → result = x^233 mod f = (1<<74)|1 = 0x…0400_0000_0000_0000_0001 (bits 74 and 0 set only).
- A=0, B=all-ones; then A=(1<<255)|3, B=1 → first result=0; second result=3, proving upper bits are ignored and result[255:233]=0.
- FIFO A holds 2 entries, FIFO B is empty for 50 cycles, then B is written → no rd_en for the whole 50 cycles; the pair is popped only after B becomes non-empty.
- result_ready held 0 for 20 cycles at DONE, with both FIFOs still non-empty → result and result_valid stable, no rd_en. After result_ready=1, the next FETCH follows 2 cycles later.
- rst pulsed at MUL iteration 100 → all outputs 0 on the same edge. After release, the next FIFO pair is processed correctly and the aborted pair produces no result.
